// File: rtl/coef_bank_pkg.sv
// coef_bank_pkg: shared types and constants for the coefficient bank.
// Holds the commit FSM state type, the per-entry reset value and the
// index of the hard-wired zero entry.
package coef_bank_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } coef_state_t;

   // Entry 0 of every bank always reads as zero and is never stored.
   localparam int ZERO_IDX = 0;

   // Reset contents of entry k; the caller truncates to the coefficient width,
   // which gives k mod 2^WIDTH.
   function automatic logic [63:0] coef_reset_val(input int k);
      return 64'(k);
   endfunction

endpackage

// File: rtl/coef_regfile.sv
// coef_regfile: one coefficient bank. Stores entries 1..NUM_COEF-1 (entry 0
// is the zero entry and has no storage). Provides a single write port, a
// bulk-load input that replaces all stored entries in one edge, and the whole
// stored contents as a flat vector for combinational reads.
// Entry k lives at bits [(k-1)*WIDTH +: WIDTH] of data / load_data.
module coef_regfile
   import coef_bank_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NUM_COEF = 4,
   parameter int SEL_W    = $clog2(NUM_COEF)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            wr_en,
   input  logic [SEL_W-1:0]                wr_addr,
   input  logic [WIDTH-1:0]                wr_data,
   input  logic                            load_en,
   input  logic [(NUM_COEF-1)*WIDTH-1:0]   load_data,
   output logic [(NUM_COEF-1)*WIDTH-1:0]   data
);

   // Bank storage: reset values, bulk load has priority, then single writes.
   // Writes to the zero entry or past the last entry match no slot and vanish.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 1; k < NUM_COEF; k++) begin
            data[(k-1)*WIDTH +: WIDTH] <= WIDTH'(coef_reset_val(k));
         end
      end else if (load_en) begin
         data <= load_data;
      end else if (wr_en) begin
         for (int k = 1; k < NUM_COEF; k++) begin
            if (int'(wr_addr) == k && k != ZERO_IDX) begin
               data[(k-1)*WIDTH +: WIDTH] <= wr_data;
            end
         end
      end
   end

endmodule

// File: rtl/coef_bank.sv
// coef_bank: double-buffered programmable coefficient bank.
// Software writes the shadow bank, requests a commit, and the shadow contents
// are copied into the active bank on the next sample tick. The active bank
// drives a registered output updated once per sample tick.
// Optional feature macro: COEF_READBACK_EN adds rd_addr/rd_data, a
// combinational read of the shadow bank.
//
// Write handshake: a write is accepted in any cycle where wr_en and wr_ready
// are both high; wr_ready depends only on the FSM state (low while a commit
// is pending), so a write is never stalled, it is either taken or dropped.
module coef_bank
   import coef_bank_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NUM_COEF = 4,
   parameter int SEL_W    = $clog2(NUM_COEF)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_tick,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] coeficiente,
   output logic             coef_valid,
   input  logic             wr_en,
   input  logic [SEL_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_ready,
   input  logic             commit_req,
   output logic             commit_busy,
`ifdef COEF_READBACK_EN
   input  logic [SEL_W-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data,
`endif
   output logic             fsm_state
);

   localparam int BANK_W = (NUM_COEF - 1) * WIDTH;

   coef_state_t       state_q;
   coef_state_t       state_d;
   logic              swap;
   logic              shadow_we;
   logic [BANK_W-1:0] shadow_data;
   logic [BANK_W-1:0] active_data;
   logic [WIDTH-1:0]  sel_coef;

   coef_regfile #(
      .WIDTH    (WIDTH),
      .NUM_COEF (NUM_COEF),
      .SEL_W    (SEL_W)
   ) u_shadow (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (shadow_we),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .load_en   (1'b0),
      .load_data ({BANK_W{1'b0}}),
      .data      (shadow_data)
   );

   coef_regfile #(
      .WIDTH    (WIDTH),
      .NUM_COEF (NUM_COEF),
      .SEL_W    (SEL_W)
   ) u_active (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (1'b0),
      .wr_addr   ({SEL_W{1'b0}}),
      .wr_data   ({WIDTH{1'b0}}),
      .load_en   (swap),
      .load_data (shadow_data),
      .data      (active_data)
   );

   // Commit FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Commit FSM next state: arm on request, release on the following tick.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (commit_req)  state_d = ARMED;
         ARMED:   if (sample_tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Commit FSM outputs: shadow frozen while armed, swap on the releasing tick.
   always_comb begin
      wr_ready    = (state_q == IDLE);
      commit_busy = (state_q == ARMED);
      swap        = (state_q == ARMED) && sample_tick;
      shadow_we   = wr_en && (state_q == IDLE);
   end

   assign fsm_state = (state_q == ARMED);

   // Select mux over the active bank; zero entry and out-of-range give 0.
   always_comb begin
      sel_coef = '0;
      for (int k = 1; k < NUM_COEF; k++) begin
         if (int'(sel) == k) sel_coef = active_data[(k-1)*WIDTH +: WIDTH];
      end
   end

   // Output register: captures the pre-swap active entry on each tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         coeficiente <= '0;
         coef_valid  <= 1'b0;
      end else begin
         coef_valid <= sample_tick;
         if (sample_tick) coeficiente <= sel_coef;
      end
   end

`ifdef COEF_READBACK_EN
   // Shadow readback mux; zero entry and out-of-range give 0.
   always_comb begin
      rd_data = '0;
      for (int k = 1; k < NUM_COEF; k++) begin
         if (int'(rd_addr) == k) rd_data = shadow_data[(k-1)*WIDTH +: WIDTH];
      end
   end
`endif

endmodule
